// File: rtl/e3_pkg.sv
// Shared Excess-3 constants and the per-digit decode result type.
package e3_pkg;
  localparam int         DIGIT_W       = 4;
  localparam logic [3:0] E3_OFFSET     = 4'd3;
  localparam logic [3:0] E3_MIN        = 4'b0011;
  localparam logic [3:0] E3_MAX        = 4'b1100;
  localparam logic [3:0] E3_BAD_NIBBLE = 4'hF;

  typedef struct packed {
    logic [DIGIT_W-1:0] bcd;
    logic               err;
  } e3_dec_t;
endpackage

// File: rtl/excess3_digit_decode.sv
// Combinational Excess-3 nibble -> BCD decoder.
// With E3_ERR_CHECK_EN defined, out-of-range codes flag err and decode to E3_BAD_NIBBLE.
module excess3_digit_decode
  import e3_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [DIGIT_W-1:0] bcd,
  output logic               err
);
  e3_dec_t dec;

  always_comb begin
    dec.err = 1'b0;
    dec.bcd = code - E3_OFFSET;
`ifdef E3_ERR_CHECK_EN
    if (code < E3_MIN || code > E3_MAX) begin
      dec.err = 1'b1;
      dec.bcd = E3_BAD_NIBBLE;
    end
`endif
  end

  assign bcd = dec.bcd;
  assign err = dec.err;
endmodule

// File: rtl/excess3_serial_collector.sv
// Serial LSB-first Excess-3 collector: frames bits into DIGITS-digit words, decodes to BCD,
// holds one word on a ready/valid port and flags dropped words. Optional check: E3_ERR_CHECK_EN.
module excess3_serial_collector
  import e3_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      x_in,
  input  logic                      x_valid,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [DIGIT_W*DIGITS-1:0] digit_out,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      overrun,
  output logic                      code_err
);
  localparam int          CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  logic [1:0]                         bit_cnt;
  logic [CW-1:0]                      dig_cnt;
  logic [2:0]                         sr;
  logic [DIGITS-1:0][DIGIT_W-1:0]     slots;
  logic [DIGITS-1:0][DIGIT_W-1:0]     word;
  logic [DIGITS-1:0][DIGIT_W-1:0]     bcd_w;
  logic [DIGITS-1:0]                  err_w;
  logic [DIGIT_W-1:0]                 nibble;
  logic                               nib_done, complete, accept, load;

  assign nibble   = {x_in, sr};
  assign nib_done = x_valid && (bit_cnt == 2'd3);
  assign complete = nib_done && (dig_cnt == LAST);
  assign accept   = out_valid && out_ready;
  assign load     = complete && (!out_valid || out_ready);

  // The completing nibble bypasses its slot so the word is whole on the same edge.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign word[i] = (dig_cnt == CW'(i)) ? nibble : slots[i];
    excess3_digit_decode u_dec (
      .code (word[i]),
      .bcd  (bcd_w[i]),
      .err  (err_w[i])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt <= '0;
      dig_cnt <= '0;
      sr      <= '0;
      slots   <= '0;
    end else if (x_valid) begin
      sr      <= {x_in, sr[2:1]};
      bit_cnt <= bit_cnt + 2'd1;
      if (nib_done) begin
        slots[dig_cnt] <= nibble;
        dig_cnt        <= (dig_cnt == LAST) ? '0 : dig_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      digit_out <= '0;
      bcd_out   <= '0;
      code_err  <= 1'b0;
      overrun   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      digit_out <= word;
      bcd_out   <= bcd_w;
      code_err  <= |err_w;
    end else begin
      // A completed word that cannot load implies a held, unaccepted word.
      if (complete) overrun   <= 1'b1;
      if (accept)   out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_excess3_serial_collector.sv
// Self-checking bench: bit-count/word model compared every cycle, plus directed literal checks.
module tb_excess3_serial_collector;
  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

  logic clock = 1'b0;
  logic reset;
  logic x_in = 1'b0, x_valid = 1'b0, out_ready = 1'b0;
  logic out_valid, overrun, code_err;
  logic [W-1:0] digit_out, bcd_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  excess3_serial_collector #(.DIGITS(DIGITS)) dut (
    .clock     (clock),
    .reset     (reset),
    .x_in      (x_in),
    .x_valid   (x_valid),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .digit_out (digit_out),
    .bcd_out   (bcd_out),
    .overrun   (overrun),
    .code_err  (code_err)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count qualified bits since reset; every W bits is a word.
  int           mk = 0;
  logic [W-1:0] macc = '0;
  logic         m_valid = 1'b0, m_ovr = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_dig = '0, m_bcd = '0;

  function automatic void decode(input logic [W-1:0] w, output logic [W-1:0] b, output logic e);
    logic [3:0] d;
    b = '0;
    e = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      d = w[4*i +: 4];
      b[4*i +: 4] = d - 4'd3;
`ifdef E3_ERR_CHECK_EN
      if (d < 4'd3 || d > 4'd12) begin
        b[4*i +: 4] = 4'hF;
        e = 1'b1;
      end
`endif
    end
  endfunction

  always @(posedge clock or negedge reset) begin
    logic         done;
    logic [W-1:0] w, b;
    logic         e;
    if (!reset) begin
      mk = 0; macc = '0; m_valid = 0; m_ovr = 0; m_err = 0; m_dig = '0; m_bcd = '0;
    end else begin
      done = 1'b0;
      w = '0;
      if (x_valid) begin
        macc[mk] = x_in;
        mk++;
        if (mk == W) begin
          done = 1'b1; w = macc; mk = 0; macc = '0;
        end
      end
      if (done) begin
        if (!m_valid || out_ready) begin
          decode(w, b, e);
          m_valid = 1'b1; m_dig = w; m_bcd = b; m_err = e;
        end else m_ovr = 1'b1;
      end else if (m_valid && out_ready) m_valid = 1'b0;
    end
  end

  always @(negedge clock) begin
    chk("out_valid", W'(out_valid), W'(m_valid));
    chk("digit_out", digit_out, m_dig);
    chk("bcd_out",   bcd_out,   m_bcd);
    chk("overrun",   W'(overrun),  W'(m_ovr));
    chk("code_err",  W'(code_err), W'(m_err));
  end

  task automatic step(input logic b, input logic v, input logic r);
    @(posedge clock);
    #2;
    x_in = b; x_valid = v; out_ready = r;
  endtask

  task automatic send_word(input logic [W-1:0] bits, input logic r, input logic last_r);
    for (int k = 0; k < W; k++) step(bits[k], 1'b1, (k == W-1) ? last_r : r);
  endtask

  task automatic idle(input int n, input logic r);
    repeat (n) step(1'b0, 1'b0, r);
  endtask

  initial begin
    reset = 1'b0;
    #6 reset = 1'b1;

    idle(3, 1'b0);
    @(negedge clock);
    chk("rst_valid", W'(out_valid), '0);
    chk("rst_digit", digit_out, '0);

    // digits 3,4 -> 8'h43 / BCD 10
    send_word(8'h43, 1'b0, 1'b0);
    step(0, 0, 0);
    @(negedge clock);
    chk("w1_valid", W'(out_valid), 8'h01);
    chk("w1_digit", digit_out, 8'h43);
    chk("w1_bcd",   bcd_out,   8'h10);
    chk("w1_err",   W'(code_err), 8'h00);
    idle(2, 1'b1);

    repeat (4) send_word(8'h8C, 1'b1, 1'b1);
    step(0, 0, 1);
    @(negedge clock);
    chk("b2b_digit", digit_out, 8'h8C);
    chk("b2b_bcd",   bcd_out,   8'h59);
    chk("b2b_ovr",   W'(overrun), 8'h00);
    idle(2, 1'b1);

    send_word(8'h43, 1'b0, 1'b0);
    send_word(8'h8C, 1'b0, 1'b0);
    step(0, 0, 0);
    @(negedge clock);
    chk("ovr_digit", digit_out, 8'h43);
    chk("ovr_flag",  W'(overrun), 8'h01);

    step(1, 1, 0);
    step(1, 1, 0);
    @(posedge clock);
    #2;
    reset = 1'b0; x_valid = 1'b0;
    #10 reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_ovr",   W'(overrun),   8'h00);
    chk("mid_rst_valid", W'(out_valid), 8'h00);
    send_word(8'h8C, 1'b0, 1'b0);
    step(0, 0, 0);
    @(negedge clock);
    chk("mid_rst_digit", digit_out, 8'h8C);

    // ready only on the completion edge of the next word
    send_word(8'h43, 1'b0, 1'b1);
    step(0, 0, 0);
    @(negedge clock);
    chk("sim_valid", W'(out_valid), 8'h01);
    chk("sim_digit", digit_out, 8'h43);
    chk("sim_ovr",   W'(overrun), 8'h00);
    idle(2, 1'b1);

    send_word(8'hCF, 1'b0, 1'b0);
    step(0, 0, 0);
    @(negedge clock);
    chk("inv_bcd1", W'(bcd_out[7:4]), 8'h09);
`ifdef E3_ERR_CHECK_EN
    chk("inv_err",  W'(code_err), 8'h01);
    chk("inv_bcd0", W'(bcd_out[3:0]), 8'h0F);
`else
    chk("inv_err",  W'(code_err), 8'h00);
    chk("inv_bcd0", W'(bcd_out[3:0]), 8'h0C);
`endif
    idle(2, 1'b1);

    repeat (600) step(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    idle(2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
